// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared width default, opcodes, FSM encoding and opcode legality helper
package alu_arbiter_pkg;
  localparam int WIDTH_DEF = 32;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_XNOR = 4'hB;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd2} state_t;
  function automatic logic op_legal(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_XNOR};
  endfunction
endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu: combinational ALU; Result = op I applied to A, B (unknown opcodes give 0)
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  output logic [WIDTH-1:0] Result,
  input  logic [3:0]       I,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B
);
  always_comb
    Result = (I == OP_ADD)  ? A + B :
             (I == OP_SUB)  ? A - B :
             (I == OP_AND)  ? A & B :
             (I == OP_OR)   ? A | B :
             (I == OP_XOR)  ? A ^ B :
             (I == OP_XNOR) ? ~(A ^ B) : '0;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end sharing one ALU (IDLE -> EXEC -> RESP)
// ports: clk, rst_n (async, active-low); req0_*/req1_* valid/ready/op/a/b requests;
//        rsp_valid/rsp_ready handshake with rsp_id, rsp_result, rsp_err response
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_err
);
  state_t           r_state, w_next;
  logic             r_last_grant, r_id, r_rsp_id, r_rsp_err;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_rsp_result, w_alu;
  logic             w_gnt, w_accept;
  // tie goes to whoever was not granted last; a lone requester always wins
  assign w_gnt = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
  always_comb begin
    w_accept = rst_n && (r_state == S_IDLE) && (req0_valid || req1_valid);
    w_next   = (r_state == S_IDLE) ? (w_accept ? S_EXEC : S_IDLE) :
               (r_state == S_EXEC) ? S_RESP :
               (r_state == S_RESP && !rsp_ready) ? S_RESP : S_IDLE;
  end
  assign req0_ready = w_accept && !w_gnt;
  assign req1_ready = w_accept && w_gnt;
  assign rsp_valid  = (r_state == S_RESP);
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_err    = r_rsp_err;
  alu_arbiter_alu #(.WIDTH(WIDTH)) u_alu (.Result(w_alu), .I(r_op), .A(r_a), .B(r_b));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_last_grant <= w_gnt;
        r_id         <= w_gnt;
        r_op         <= w_gnt ? req1_op : req0_op;
        r_a          <= w_gnt ? req1_a : req0_a;
        r_b          <= w_gnt ? req1_b : req0_b;
      end
      if (r_state == S_EXEC) begin
        r_rsp_id     <= r_id;
        r_rsp_err    <= !op_legal(r_op);
        r_rsp_result <= op_legal(r_op) ? w_alu : '0;
      end
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, datapath width of operands and result.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_op  input  4  requester 0 ALU opcode.
REQ-007 req0_a, req0_b  input  WIDTH each  requester 0 operands.
REQ-008 req1_valid, req1_ready, req1_op, req1_a, req1_b  same directions/widths/meanings as REQ-004..007, for requester 1.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer takes result this cycle.
REQ-011 rsp_id  output  1  index of requester that issued the result.
REQ-012 rsp_result  output  WIDTH  ALU result.
REQ-013 rsp_err  output  1  opcode was unsupported.

Function
REQ-014 Opcodes: 0x0 add A+B, 0x1 sub A-B, 0x8 and, 0x9 or, 0xA xor, 0xB xnor; add/sub modulo 2^WIDTH, carry/overflow discarded.
REQ-015 Any other opcode: rsp_result = 0, rsp_err = 1; otherwise rsp_err = 0.
REQ-016 FSM states IDLE, EXEC, RESP; IDLE -> EXEC on accept; EXEC -> RESP unconditionally; RESP -> IDLE when rsp_ready = 1.
REQ-017 Accept = (state IDLE) and reqN_valid and grant to N; reqN_ready asserted combinationally only in that cycle; never in EXEC or RESP.
REQ-018 On accept: op, A, B and requester id latched into operand registers.
REQ-019 In EXEC: shared ALU evaluates latched operands; result, err, id registered into response registers at the EXEC->RESP edge.
REQ-020 Latency: accept at edge N -> rsp_valid = 1 after edge N+2; rsp_* stable while rsp_valid = 1 and rsp_ready = 0.
REQ-021 rsp_valid = 1 exactly in RESP; rsp_result/rsp_id/rsp_err hold last value outside RESP.
REQ-022 Arbitration round-robin: single pointer last_grant; only one valid -> grant it; both valid -> grant requester != last_grant; last_grant updates only on accept.
REQ-023 Throughput: at most one accept per 3 cycles with rsp_ready tied high (IDLE, EXEC, RESP); new accept earliest in IDLE following RESP.
REQ-024 Requester deasserting valid in a cycle it is not accepted: no effect, no state change.
REQ-025 rsp_ready while not in RESP: ignored.
REQ-026 Fairness: with both valid continuously, grants alternate 0,1,0,1,...; no requester waits more than one other transaction.

Reset
REQ-027 rst_n low asynchronously forces: state IDLE, last_grant = 1 (requester 0 wins first tie), rsp_valid = 0, rsp_result = 0, rsp_id = 0, rsp_err = 0, operand registers 0, req0_ready = req1_ready = 0.
REQ-028 Reset mid-transaction (EXEC or RESP) discards the operation; no response issued after release.
REQ-029 First accept possible in first rising edge after rst_n deasserts.

Structure
REQ-030 Shared package: WIDTH default, opcode constants (OP_ADD=0x0, OP_SUB=0x1, OP_AND=0x8, OP_OR=0x9, OP_XOR=0xA, OP_XNOR=0xB), FSM state encoding.
REQ-031 Single sub-module: existing combinational ALU instance (port order Result, I, A, B) driven from operand registers; opcode legality check in alu_arbiter.
REQ-032 No other datapath logic outside the ALU instance beyond registers and muxes.

Verification
REQ-033 Single request: req0 op 0x0, A=5, B=5, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_result=0x0000000A, rsp_id=0, rsp_err=0.
REQ-034 Contention: both valid from reset, req0 sub 0xA-0x2, req1 xor 0xAAAAAAAA^0xDDDDDDDD -> first rsp id0 result 0x00000008, second rsp id1 result 0x77777777; grants alternate over 6 back-to-back ops.
REQ-035 Back-pressure: rsp_ready=0 for 5 cycles in RESP with req1 valid -> rsp_* stable, req1_ready stays 0; rsp_ready=1 -> IDLE then req1 accepted.
REQ-036 Wrap/edge arithmetic: add 0x7FFFFFFF+0x8FFFFFFF -> 0x0FFFFFFE; sub 0x0-0xFFFFFFFF -> 0x00000001; xnor 0xAAAAAAAA,0xAAAAAAAA -> 0xFFFFFFFF.
REQ-037 Illegal op 0x5 -> rsp_result=0, rsp_err=1, arbitration unaffected.
REQ-038 rst_n pulsed low during EXEC -> outputs reset immediately, no rsp_valid afterwards until a new accept; first tie after release goes to req0.
